// File: rtl/eim_reg_bank.sv
// eim_reg_bank: strobe-driven register bank with read-only status slots,
// self-clearing pulse registers and a fixed-latency read pipeline.
module eim_reg_bank #(
  parameter int                 DW         = 16,
  parameter int                 NUM_REG    = 16,
  parameter logic [15:0]        BASE_ADDR  = 16'h0000,
  parameter logic [NUM_REG-1:0] RO_MASK    = '0,
  parameter logic [NUM_REG-1:0] PULSE_MASK = '0,
  parameter int                 RD_LAT     = 2
) (
  input  logic                  eim_clk,
  input  logic                  eim_rst,
  input  logic [15:0]           reg_addr,
  input  logic [DW-1:0]         reg_data,
  input  logic                  reg_addr_index,
  input  logic                  reg_data_index,
  input  logic                  reg_read_index,
  input  logic [NUM_REG*DW-1:0] status_in,
  output logic [DW-1:0]         reg_read_out,
  output logic                  read_data_en,
  output logic [NUM_REG*DW-1:0] ctrl_out,
  output logic                  wr_err,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE,
    RD_PIPE,
    RD_DONE
  } state_e;

  localparam logic [1:0] LAST = 2'(RD_LAT - 1);

  state_e               state_q, state_d;
  logic [1:0]           cnt_q, cnt_d;
  logic                 wr_req_q, wr_req_d;
  logic                 rd_req_q, rd_req_d;
  logic [NUM_REG-1:0]   rd_sel_q, rd_sel_d;
  logic [DW-1:0]        rdata_q, rdata_d;
  logic                 rvalid_q, rvalid_d;
  logic                 wr_err_q, wr_err_d;
  logic                 busy_q, busy_d;
  logic [DW-1:0]        regs_q [NUM_REG];
  logic [DW-1:0]        regs_d [NUM_REG];

  logic                 wr_req, rd_req;
  logic                 wr_edge, rd_edge;
  logic [15:0]          off;
  logic                 in_range;
  logic [NUM_REG-1:0]   sel;
  logic                 wr_ok;
  logic [DW-1:0]        rd_mux;

  assign wr_req  = reg_addr_index & reg_data_index;
  assign rd_req  = reg_addr_index & reg_read_index & ~reg_data_index;
  assign wr_edge = wr_req & ~wr_req_q;
  assign rd_edge = rd_req & ~rd_req_q;

  // 17-bit upper bound so a bank ending at 16'hFFFF cannot wrap
  always_comb begin
    off      = reg_addr - BASE_ADDR;
    in_range = (reg_addr >= BASE_ADDR) &&
               ({1'b0, reg_addr} <
                ({1'b0, BASE_ADDR} + 17'(NUM_REG)));
    sel = '0;
    for (int i = 0; i < NUM_REG; i++) begin
      sel[i] = in_range && (off == 16'(i));
    end
    wr_ok = |(sel & ~RO_MASK);
  end

  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NUM_REG; i++) begin
      if (rd_sel_q[i]) begin
        rd_mux = RO_MASK[i] ? status_in[i*DW +: DW]
                            : regs_q[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_REG; i++) begin
      if (RO_MASK[i]) begin
        regs_d[i] = '0;
      end else if (wr_edge && sel[i]) begin
        regs_d[i] = reg_data;
      end else if (PULSE_MASK[i]) begin
        regs_d[i] = '0;
      end else begin
        regs_d[i] = regs_q[i];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rd_sel_d = rd_sel_q;
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
    wr_err_d = wr_edge & ~wr_ok;
    wr_req_d = wr_req;
    rd_req_d = rd_req;
    unique case (state_q)
      IDLE: begin
        if (rd_edge) begin
          state_d  = RD_PIPE;
          cnt_d    = '0;
          rd_sel_d = sel;
        end
      end
      RD_PIPE: begin
        if (cnt_q == LAST) begin
          state_d = RD_DONE;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      RD_DONE: begin
        state_d  = IDLE;
        rvalid_d = 1'b1;
        rdata_d  = rd_mux;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge eim_clk or negedge eim_rst) begin
    if (!eim_rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      wr_req_q <= 1'b0;
      rd_req_q <= 1'b0;
      rd_sel_q <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      wr_err_q <= 1'b0;
      busy_q   <= 1'b0;
      for (int i = 0; i < NUM_REG; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wr_req_q <= wr_req_d;
      rd_req_q <= rd_req_d;
      rd_sel_q <= rd_sel_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      wr_err_q <= wr_err_d;
      busy_q   <= busy_d;
      for (int i = 0; i < NUM_REG; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_REG; i++) begin
      ctrl_out[i*DW +: DW] = regs_q[i];
    end
  end

  assign reg_read_out = rdata_q;
  assign read_data_en = rvalid_q;
  assign wr_err       = wr_err_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_eim_reg_bank.sv
// tb_eim_reg_bank: scoreboard bench for eim_reg_bank; reads push expected
// data and completion cycle, a negedge monitor pops and compares.
module tb_eim_reg_bank;

  parameter int RD_LAT = 2;

  localparam int DW = 16;
  localparam int NR = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [15:0]      reg_addr;
  logic [DW-1:0]    reg_data;
  logic             ai, di, ri;
  logic [NR*DW-1:0] status_in;
  logic [DW-1:0]    reg_read_out;
  logic             read_data_en;
  logic [NR*DW-1:0] ctrl_out;
  logic             wr_err;
  logic             busy;

  typedef struct {
    logic [15:0] data;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  eim_reg_bank #(
    .DW        (DW),
    .NUM_REG   (NR),
    .BASE_ADDR (16'h0000),
    .RO_MASK   (16'h0008),
    .PULSE_MASK(16'h0020),
    .RD_LAT    (RD_LAT)
  ) dut (
    .eim_clk       (clk),
    .eim_rst       (rst_n),
    .reg_addr      (reg_addr),
    .reg_data      (reg_data),
    .reg_addr_index(ai),
    .reg_data_index(di),
    .reg_read_index(ri),
    .status_in     (status_in),
    .reg_read_out  (reg_read_out),
    .read_data_en  (read_data_en),
    .ctrl_out      (ctrl_out),
    .wr_err        (wr_err),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] slc(input int i);
    return ctrl_out[i*DW +: DW];
  endfunction

  always @(negedge clk) begin
    if (read_data_en) begin
      if (sb.size() == 0) begin
        chk("spurious_rd", read_data_en, 1'b0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("rd_data", reg_read_out, e.data);
        chk("rd_lat", cyc, e.cyc);
      end
    end
  end

  task automatic wait_done();
    for (int k = 0; k < 20; k++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
      #1;
    end
    chk("rd_timeout", sb.size(), 0);
    chk("busy_idle", busy, 1'b0);
  endtask

  task automatic do_write(input logic [15:0] a,
                          input logic [15:0] d,
                          input logic        e);
    @(negedge clk);
    reg_addr = a; reg_data = d; ai = 1'b1; di = 1'b1;
    @(negedge clk);
    chk("wr_err", wr_err, e);
    ai = 1'b0; di = 1'b0;
    @(negedge clk);
    chk("wr_err_clr", wr_err, 1'b0);
  endtask

  task automatic do_read(input logic [15:0] a,
                         input logic [15:0] x);
    @(negedge clk);
    reg_addr = a; ai = 1'b1; ri = 1'b1;
    sb.push_back('{x, cyc + RD_LAT + 2});
    @(negedge clk);
    chk("busy", busy, 1'b1);
    ai = 1'b0; ri = 1'b0;
    wait_done();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout t=%0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    reg_addr = '0; reg_data = '0;
    ai = 1'b0; di = 1'b0; ri = 1'b0;
    for (int i = 0; i < NR; i++) begin
      status_in[i*DW +: DW] = 16'(16'h1100 + i);
    end
    status_in[3*DW +: DW] = 16'hBEEF;
    repeat (2) @(negedge clk);
    chk("rst_ctrl", |ctrl_out, 1'b0);
    chk("rst_rdo", reg_read_out, 16'h0);
    chk("rst_rde", read_data_en, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_err", wr_err, 1'b0);
    rst_n = 1'b1;

    // basic write then read
    do_write(16'h0001, 16'h1234, 1'b0);
    chk("ctrl1", ctrl_out[31:16], 16'h1234);
    do_read(16'h0001, 16'h1234);

    // held strobe writes once
    @(negedge clk);
    reg_addr = 16'h0002; reg_data = 16'hAAAA;
    ai = 1'b1; di = 1'b1;
    repeat (4) @(negedge clk);
    reg_data = 16'h5555;
    repeat (2) @(negedge clk);
    chk("held_wr", slc(2), 16'hAAAA);
    ai = 1'b0; di = 1'b0;
    @(negedge clk);
    chk("held_wr2", slc(2), 16'hAAAA);
    do_read(16'h0002, 16'hAAAA);

    // read-only and range
    do_write(16'h0003, 16'hFFFF, 1'b1);
    chk("ro_ctrl", slc(3), 16'h0000);
    do_read(16'h0003, 16'hBEEF);
    do_write(16'h0010, 16'h1111, 1'b1);
    do_write(16'hFFFF, 16'h2222, 1'b1);
    do_read(16'h0010, 16'h0000);
    do_write(16'h000F, 16'h0F0F, 1'b0);
    do_read(16'h000F, 16'h0F0F);

    // self-clearing register
    @(negedge clk);
    reg_addr = 16'h0005; reg_data = 16'h0001;
    ai = 1'b1; di = 1'b1;
    @(negedge clk);
    chk("pulse_on", slc(5), 16'h0001);
    ai = 1'b0; di = 1'b0;
    @(negedge clk);
    chk("pulse_off", slc(5), 16'h0000);

    // write during read pipe, second read edge ignored
    @(negedge clk);
    reg_addr = 16'h0001; ai = 1'b1; ri = 1'b1;
    sb.push_back('{16'h4321, cyc + RD_LAT + 2});
    @(negedge clk);
    ri = 1'b0; di = 1'b1; reg_data = 16'h4321;
    @(negedge clk);
    chk("pipe_wr", slc(1), 16'h4321);
    di = 1'b0; reg_addr = 16'h0002; ri = 1'b1;
    @(negedge clk);
    ai = 1'b0; ri = 1'b0;
    wait_done();
    repeat (8) @(negedge clk);

    // simultaneous write and read: write only
    @(negedge clk);
    reg_addr = 16'h0006; reg_data = 16'h0606;
    ai = 1'b1; di = 1'b1; ri = 1'b1;
    @(negedge clk);
    chk("sim_err", wr_err, 1'b0);
    chk("sim_ctrl", slc(6), 16'h0606);
    chk("sim_busy", busy, 1'b0);
    ai = 1'b0; di = 1'b0; ri = 1'b0;
    repeat (8) @(negedge clk);

    // reset mid-read
    @(negedge clk);
    reg_addr = 16'h0001; ai = 1'b1; ri = 1'b1;
    @(negedge clk);
    ai = 1'b0; ri = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    chk("mr_ctrl", |ctrl_out, 1'b0);
    chk("mr_rdo", reg_read_out, 16'h0);
    chk("mr_rde", read_data_en, 1'b0);
    chk("mr_busy", busy, 1'b0);
    chk("mr_err", wr_err, 1'b0);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("mr_idle", busy, 1'b0);
    do_write(16'h0007, 16'h0BAD, 1'b0);
    do_read(16'h0007, 16'h0BAD);
    do_read(16'h0001, 16'h0000);

    repeat (4) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
